// File: rtl/period_timer_ctrl.sv
// Programmable interval timer with prescaler and one-shot/periodic modes.
// State and all outputs update on the falling edge of clk.
module period_timer_ctrl #(
    parameter int N = 8,
    parameter int P = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         stop,
    input  logic         periodic,
    input  logic [N-1:0] period,
    input  logic [P-1:0] prescale,
    output logic [N-1:0] count,
    output logic         tick,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   count_q, count_d;
    logic [P-1:0]   psc_q, psc_d;
    logic [N-1:0]   period_q, period_d;
    logic [P-1:0]   prescale_q, prescale_d;
    logic           periodic_q, periodic_d;
    logic           tick_q, tick_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        psc_d      = psc_q;
        period_d   = period_q;
        prescale_d = prescale_q;
        periodic_d = periodic_q;
        tick_d     = 1'b0;
        err_d      = 1'b0;

        if (stop) begin
            state_d = IDLE;
            count_d = '0;
            psc_d   = '0;
        end else if (start && period != '0) begin
            // Restart also suppresses any expiry due on this edge.
            state_d    = RUN;
            count_d    = '0;
            psc_d      = '0;
            period_d   = period;
            prescale_d = prescale;
            periodic_d = periodic;
        end else begin
            err_d = start;
            unique case (state_q)
                RUN: begin
                    if (psc_q == prescale_q) begin
                        psc_d = '0;
                        if (count_q == period_q - N'(1)) begin
                            count_d = '0;
                            tick_d  = 1'b1;
                            if (!periodic_q) state_d = DONE;
                        end else begin
                            count_d = count_q + N'(1);
                        end
                    end else begin
                        psc_d = psc_q + P'(1);
                    end
                end
                IDLE, DONE: ;
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            psc_q      <= '0;
            period_q   <= '0;
            prescale_q <= '0;
            periodic_q <= 1'b0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            psc_q      <= psc_d;
            period_q   <= period_d;
            prescale_q <= prescale_d;
            periodic_q <= periodic_d;
            tick_q     <= tick_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_period_timer_ctrl.sv
// Bench for period_timer_ctrl: directed scenarios plus random traffic,
// checked against an elapsed-time model of the timer.
module tb_period_timer_ctrl;

    localparam int N = 8;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic         stop;
    logic         periodic;
    logic [N-1:0] period;
    logic [P-1:0] prescale;
    logic [N-1:0] count;
    logic         tick;
    logic         busy;
    logic         done;
    logic         err;

    int checks = 0;
    int failures = 0;

    period_timer_ctrl #(.N(N), .P(P)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .period   (period),
        .prescale (prescale),
        .count    (count),
        .tick     (tick),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    wire [N+3:0] vec = {count, tick, busy, done, err};

    // Model: mode 0=idle 1=run 2=done; el = edges since the start edge.
    int m_mode, m_el, m_per, m_ps;
    bit m_pm, m_tick, m_err;

    function automatic void model_reset();
        m_mode = 0; m_el = 0; m_per = 0; m_ps = 0;
        m_pm = 0; m_tick = 0; m_err = 0;
    endfunction

    function automatic void model_step(bit s, bit sp, bit pm, int pr, int ps);
        m_tick = 0;
        m_err  = 0;
        if (sp) begin
            m_mode = 0;
        end else if (s && pr != 0) begin
            m_mode = 1; m_el = 0; m_per = pr; m_ps = ps; m_pm = pm;
        end else begin
            m_err = s;
            if (m_mode == 1) begin
                m_el++;
                if (m_el % (m_per * (m_ps + 1)) == 0) begin
                    m_tick = 1;
                    if (!m_pm) m_mode = 2;
                end
            end
        end
    endfunction

    function automatic logic [N+3:0] exp_vec();
        int c;
        logic [N-1:0] cb;
        c = (m_mode == 1) ? (m_el / (m_ps + 1)) % m_per : 0;
        cb = N'(c);
        return {cb, m_tick, m_mode == 1, m_mode == 2, m_err};
    endfunction

    task automatic cyc(input bit s, input bit sp, input bit pm,
                       input int pr, input int ps);
        start = s; stop = sp; periodic = pm;
        period = N'(pr); prescale = P'(ps);
        @(negedge clk);
        model_step(s, sp, pm, pr, ps);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 1'($urandom), $urandom_range(0, 255), $urandom_range(0, 15));
    endtask

    task automatic test_reset();
        checks++;
        if (vec !== '0) begin
            failures++;
            $display("FAIL reset got=%h exp=0", vec);
        end
        reset_n = 1'b1;
        #1;
        idle_cyc();
        checks++;
        if (vec !== exp_vec()) begin
            failures++;
            $display("FAIL reset_idle got=%h exp=%h", vec, exp_vec());
        end
    endtask

    task automatic test_periodic();
        int exp_cnt [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        cyc(1, 0, 1, 4, 1);
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) idle_cyc();
            checks++;
            if (vec !== exp_vec()) begin
                failures++;
                $display("FAIL periodic k=%0d got=%h exp=%h", k, vec, exp_vec());
            end
            if (k <= 8) begin
                checks++;
                if (count !== N'(exp_cnt[k]) || tick !== (k == 8)) begin
                    failures++;
                    $display("FAIL periodic_seq k=%0d got=%0d/%b exp=%0d/%b",
                             k, count, tick, exp_cnt[k], k == 8);
                end
            end
        end
        checks++;
        if (tick !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL periodic_2nd tick=%b busy=%b exp=1/1", tick, busy);
        end
        cyc(0, 1, 0, 0, 0);
    endtask

    task automatic test_oneshot();
        cyc(1, 0, 0, 3, 0);
        for (int k = 1; k <= 6; k++) begin
            idle_cyc();
            checks++;
            if (vec !== exp_vec()) begin
                failures++;
                $display("FAIL oneshot k=%0d got=%h exp=%h", k, vec, exp_vec());
            end
            if (k == 3) begin
                checks++;
                if (tick !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL oneshot_exp got=%b%b%b exp=110", tick, done, busy);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || count !== '0 || tick !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_hold got=%b/%0d/%b exp=1/0/0", done, count, tick);
        end
        cyc(1, 0, 0, 3, 0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || vec !== exp_vec()) begin
            failures++;
            $display("FAIL oneshot_restart got=%h exp=%h", vec, exp_vec());
        end
        cyc(0, 1, 0, 0, 0);
    endtask

    task automatic test_reject();
        cyc(1, 0, 1, 0, 2);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || vec !== exp_vec()) begin
            failures++;
            $display("FAIL reject_idle got=%h exp=%h", vec, exp_vec());
        end
        idle_cyc();
        checks++;
        if (err !== 1'b0 || vec !== exp_vec()) begin
            failures++;
            $display("FAIL reject_pulse got=%h exp=%h", vec, exp_vec());
        end
        cyc(1, 0, 1, 5, 0);
        idle_cyc();
        cyc(1, 0, 0, 0, 3);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) idle_cyc();
            checks++;
            if (vec !== exp_vec()) begin
                failures++;
                $display("FAIL reject_run k=%0d got=%h exp=%h", k, vec, exp_vec());
            end
        end
        cyc(0, 1, 0, 0, 0);
    endtask

    task automatic test_stop();
        cyc(1, 0, 1, 2, 0);
        idle_cyc();
        cyc(0, 1, 1, 2, 0);
        checks++;
        if (vec !== '0 || vec !== exp_vec()) begin
            failures++;
            $display("FAIL stop_expiry got=%h exp=0", vec);
        end
        cyc(1, 1, 1, 3, 0);
        checks++;
        if (vec !== '0) begin
            failures++;
            $display("FAIL startstop_idle got=%h exp=0", vec);
        end
        cyc(1, 0, 1, 3, 1);
        idle_cyc();
        cyc(1, 1, 1, 0, 1);
        checks++;
        if (vec !== '0 || vec !== exp_vec()) begin
            failures++;
            $display("FAIL startstop_run got=%h exp=0", vec);
        end
        idle_cyc();
        checks++;
        if (vec !== '0) begin
            failures++;
            $display("FAIL stop_stays_idle got=%h exp=0", vec);
        end
    endtask

    task automatic test_restart();
        cyc(1, 0, 1, 6, 2);
        repeat (7) idle_cyc();
        cyc(1, 0, 1, 2, 0);
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) idle_cyc();
            checks++;
            if (vec !== exp_vec() || tick !== (k == 2 || k == 4)) begin
                failures++;
                $display("FAIL restart k=%0d got=%h exp=%h", k, vec, exp_vec());
            end
        end
        idle_cyc();
        cyc(1, 0, 1, 3, 0);
        checks++;
        if (tick !== 1'b0 || count !== '0 || vec !== exp_vec()) begin
            failures++;
            $display("FAIL restart_supp got=%h exp=%h", vec, exp_vec());
        end
        cyc(0, 1, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        cyc(1, 0, 1, 5, 1);
        repeat (3) idle_cyc();
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (vec !== '0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0", vec);
        end
        #1 reset_n = 1'b1;
        model_reset();
        for (int k = 0; k < 12; k++) begin
            idle_cyc();
            checks++;
            if (vec !== '0 || vec !== exp_vec()) begin
                failures++;
                $display("FAIL reset_hold k=%0d got=%h exp=0", k, vec);
            end
        end
    endtask

    task automatic test_random();
        bit s, sp;
        for (int k = 0; k < 600; k++) begin
            s  = ($urandom_range(0, 9) == 0);
            sp = ($urandom_range(0, 24) == 0);
            cyc(s, sp, 1'($urandom), $urandom_range(0, 5), $urandom_range(0, 3));
            checks++;
            if (vec !== exp_vec()) begin
                failures++;
                $display("FAIL random k=%0d got=%h exp=%h", k, vec, exp_vec());
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0; stop = 1'b0; periodic = 1'b0;
        period = '0; prescale = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_periodic();
        test_oneshot();
        test_reject();
        test_stop();
        test_restart();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
